router_ctrl: RTL and testbench

ROUTER_CTRL -- requirements
Module: router_ctrl

---
 rtl/router_ctrl_if.sv | 33 +++
 rtl/router_ctrl.sv | 85 ++++++++
 tb/tb_router_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/router_ctrl_if.sv
// router_ctrl_if: handshake and status bundle between the router datapath and its control FSM
interface router_ctrl_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_en;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] write_enb;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       write_enb_reg;
    logic       busy;
    logic [2:0] soft_rst;
    logic [2:0] vld_out;

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, read_en, parity_done, low_pkt_valid,
        output write_enb, detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy, soft_rst, vld_out
    );

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, read_en, parity_done, low_pkt_valid,
        input  write_enb, detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy, soft_rst, vld_out
    );
endinterface

// File: rtl/router_ctrl.sv
// router_ctrl: packet-routing control FSM with per-FIFO write steering and idle timeout soft reset
module router_ctrl (
    input  logic          clk,
    input  logic          rst,
    router_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY,
        FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      addr_q, addr_d;
    logic [2:0][4:0] cnt_q, cnt_d;
    logic [2:0]      soft_rst_q, soft_rst_d;
    logic            hdr_ok;

    assign hdr_ok = bus.pkt_valid && bus.data_in != 2'd3;

    // state, address and timeout registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DECODE_ADDRESS;
            addr_q     <= '0;
            cnt_q      <= '0;
            soft_rst_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            soft_rst_q <= soft_rst_d;
        end
    end

    // next-state logic; a soft reset of the selected FIFO overrides every transition
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE_ADDRESS: if (hdr_ok) begin
                addr_d  = bus.data_in;
                state_d = bus.fifo_empty[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY:    state_d = bus.fifo_empty[addr_q] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            LOAD_DATA:          state_d = bus.fifo_full[addr_q] ? FIFO_FULL_STATE :
                                          !bus.pkt_valid ? LOAD_PARITY : LOAD_DATA;
            FIFO_FULL_STATE:    state_d = bus.fifo_full[addr_q] ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:    state_d = bus.parity_done ? DECODE_ADDRESS :
                                          bus.low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = bus.fifo_full[addr_q] ? FIFO_FULL_STATE : DECODE_ADDRESS;
        endcase
        if (soft_rst_q[addr_q]) state_d = DECODE_ADDRESS;
    end

    // per-FIFO idle timeout: 30 valid cycles without a read fire a one-cycle soft reset
    always_comb begin
        cnt_d      = cnt_q;
        soft_rst_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (!bus.vld_out[i] || bus.read_en[i]) cnt_d[i] = '0;
            else if (cnt_q[i] == 5'd29) begin
                cnt_d[i]      = '0;
                soft_rst_d[i] = 1'b1;
            end else cnt_d[i] = cnt_q[i] + 5'd1;
        end
    end

    // Moore decode and combinational steering
    always_comb begin
        bus.detect_add    = state_q == DECODE_ADDRESS;
        bus.lfd_state     = state_q == LOAD_FIRST_DATA;
        bus.ld_state      = state_q == LOAD_DATA;
        bus.laf_state     = state_q == LOAD_AFTER_FULL;
        bus.full_state    = state_q == FIFO_FULL_STATE;
        bus.rst_int_reg   = state_q == CHECK_PARITY_ERROR;
        bus.write_enb_reg = state_q == LOAD_FIRST_DATA || state_q == LOAD_DATA ||
                            state_q == LOAD_PARITY || state_q == LOAD_AFTER_FULL;
        bus.busy          = !(state_q == DECODE_ADDRESS || state_q == LOAD_DATA);
        bus.write_enb     = bus.write_enb_reg ? 3'b001 << addr_q : 3'b000;
        bus.vld_out       = ~bus.fifo_empty;
        bus.soft_rst      = soft_rst_q;
    end
endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: directed scoreboard bench for the router control FSM
module tb_router_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    router_ctrl_if bus ();
    router_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Moore output vectors {detect_add, lfd, ld, laf, full, rst_int, write_enb_reg, busy}
    localparam logic [7:0] DEC = 8'b1000_0000;
    localparam logic [7:0] LFD = 8'b0100_0011;
    localparam logic [7:0] LD  = 8'b0010_0010;
    localparam logic [7:0] LP  = 8'b0000_0011;
    localparam logic [7:0] FF  = 8'b0000_1001;
    localparam logic [7:0] LAF = 8'b0001_0011;
    localparam logic [7:0] WTE = 8'b0000_0001;
    localparam logic [7:0] CPE = 8'b0000_0101;

    logic [16:0] exp_q[$];

    task automatic check(input string tag);
        logic [16:0] g, e;
        g = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
             bus.rst_int_reg, bus.write_enb_reg, bus.busy, bus.write_enb, bus.soft_rst, bus.vld_out};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, g);
        end else begin
            e = exp_q.pop_front();
            assert (g === e) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", tag, g, e);
            end
        end
    endtask

    task automatic step(input string tag, input logic pv, input logic [1:0] din,
                        input logic [2:0] full, input logic [2:0] emp, input logic [2:0] rd,
                        input logic pd, input logic lpv,
                        input logic [7:0] mo, input logic [2:0] we, input logic [2:0] sr);
        bus.pkt_valid     = pv;
        bus.data_in       = din;
        bus.fifo_full     = full;
        bus.fifo_empty    = emp;
        bus.read_en       = rd;
        bus.parity_done   = pd;
        bus.low_pkt_valid = lpv;
        exp_q.push_back({mo, we, sr, ~emp});
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        rst = 1'b0;
        bus.pkt_valid = 1'b0; bus.data_in = 2'd0; bus.fifo_full = 3'b000; bus.fifo_empty = 3'b111;
        bus.read_en = 3'b000; bus.parity_done = 1'b0; bus.low_pkt_valid = 1'b0;
        exp_q.push_back({DEC, 3'b000, 3'b000, 3'b000});
        #1;
        check("reset");
        #10 rst = 1'b1;
        // first packet to FIFO 1
        step("a_hdr", 1, 1, 0, 7, 0, 0, 0, LFD, 3'b010, 0);
        step("a_ld",  1, 0, 0, 7, 0, 0, 0, LD,  3'b010, 0);
        step("a_ld2", 1, 0, 0, 7, 0, 0, 0, LD,  3'b010, 0);
        step("a_par", 0, 0, 0, 7, 0, 0, 0, LP,  3'b010, 0);
        step("a_cpe", 0, 0, 0, 7, 0, 0, 0, CPE, 3'b000, 0);
        step("a_dec", 0, 0, 0, 7, 0, 0, 0, DEC, 3'b000, 0);
        // 5-byte packet to FIFO 2
        step("b_hdr", 1, 2, 0, 7, 0, 0, 0, LFD, 3'b100, 0);
        step("b_d1",  1, 0, 0, 7, 0, 0, 0, LD,  3'b100, 0);
        step("b_d2",  1, 0, 0, 7, 0, 0, 0, LD,  3'b100, 0);
        step("b_d3",  1, 0, 0, 7, 0, 0, 0, LD,  3'b100, 0);
        step("b_par", 0, 0, 0, 7, 0, 0, 0, LP,  3'b100, 0);
        step("b_cpe", 0, 0, 0, 7, 0, 0, 0, CPE, 3'b000, 0);
        step("b_dec", 0, 0, 0, 7, 0, 0, 0, DEC, 3'b000, 0);
        // FIFO 0 fills mid-packet, recovers with low_pkt_valid
        step("c_hdr",  1, 0, 3'b000, 7, 0, 0, 0, LFD, 3'b001, 0);
        step("c_ld",   1, 0, 3'b000, 7, 0, 0, 0, LD,  3'b001, 0);
        step("c_full", 1, 0, 3'b001, 7, 0, 0, 0, FF,  3'b000, 0);
        step("c_hold", 1, 0, 3'b001, 7, 0, 0, 0, FF,  3'b000, 0);
        step("c_laf",  1, 0, 3'b000, 7, 0, 0, 0, LAF, 3'b001, 0);
        step("c_lpv",  0, 0, 3'b000, 7, 0, 0, 1, LP,  3'b001, 0);
        step("c_cpe",  0, 0, 3'b000, 7, 0, 0, 0, CPE, 3'b000, 0);
        step("c_dec",  0, 0, 3'b000, 7, 0, 0, 0, DEC, 3'b000, 0);
        // FIFO 1: LAF back to LD, CPE into FIFO_FULL, parity_done wins over low_pkt_valid
        step("d_hdr",  1, 1, 3'b000, 7, 0, 0, 0, LFD, 3'b010, 0);
        step("d_ld",   1, 0, 3'b000, 7, 0, 0, 0, LD,  3'b010, 0);
        step("d_full", 1, 0, 3'b010, 7, 0, 0, 0, FF,  3'b000, 0);
        step("d_laf",  1, 0, 3'b000, 7, 0, 0, 0, LAF, 3'b010, 0);
        step("d_relo", 1, 0, 3'b000, 7, 0, 0, 0, LD,  3'b010, 0);
        step("d_par",  0, 0, 3'b000, 7, 0, 0, 0, LP,  3'b010, 0);
        step("d_cpe",  0, 0, 3'b000, 7, 0, 0, 0, CPE, 3'b000, 0);
        step("d_cpff", 0, 0, 3'b010, 7, 0, 0, 0, FF,  3'b000, 0);
        step("d_laf2", 0, 0, 3'b000, 7, 0, 0, 0, LAF, 3'b010, 0);
        step("d_pd",   0, 0, 3'b000, 7, 0, 1, 1, DEC, 3'b000, 0);
        // invalid address, then wait for FIFO 0 to drain
        step("e_inv",  1, 3, 0, 7,      0, 0, 0, DEC, 3'b000, 0);
        step("e_inv2", 1, 3, 0, 7,      0, 0, 0, DEC, 3'b000, 0);
        step("e_wte",  1, 0, 0, 3'b110, 0, 0, 0, WTE, 3'b000, 0);
        step("e_wtah", 1, 0, 0, 3'b110, 0, 0, 0, WTE, 3'b000, 0);
        step("e_lfd",  1, 0, 0, 7,      0, 0, 0, LFD, 3'b001, 0);
        step("e_ld",   1, 0, 0, 7,      0, 0, 0, LD,  3'b001, 0);
        step("e_par",  0, 0, 0, 7,      0, 0, 0, LP,  3'b001, 0);
        step("e_cpe",  0, 0, 0, 7,      0, 0, 0, CPE, 3'b000, 0);
        step("e_dec",  0, 0, 0, 7,      0, 0, 0, DEC, 3'b000, 0);
        // FIFO 1 idle timeout aborts a packet in LOAD_DATA
        step("f_hdr",  1, 1, 0, 7, 0, 0, 0, LFD, 3'b010, 0);
        step("f_ld",   1, 0, 0, 7, 0, 0, 0, LD,  3'b010, 0);
        for (int k = 1; k <= 30; k++)
            step($sformatf("f_idle%0d", k), 1, 0, 0, 3'b101, 0, 0, 0, LD, 3'b010,
                 k == 30 ? 3'b010 : 3'b000);
        step("f_srst", 0, 0, 0, 3'b101, 0, 0, 0, DEC, 3'b000, 0);
        step("f_clr",  0, 0, 0, 7,      0, 0, 0, DEC, 3'b000, 0);
        // a read at cycle 20 restarts the count, so the pulse lands at cycle 50
        for (int k = 1; k <= 52; k++)
            step($sformatf("f_rd%0d", k), 0, 0, 0, 3'b101, k == 20 ? 3'b010 : 3'b000, 0, 0,
                 DEC, 3'b000, k == 50 ? 3'b010 : 3'b000);
        step("f_end", 0, 0, 0, 7, 0, 0, 0, DEC, 3'b000, 0);
        // asynchronous reset mid-packet
        step("g_hdr", 1, 2, 0, 7, 0, 0, 0, LFD, 3'b100, 0);
        step("g_ld",  1, 0, 0, 7, 0, 0, 0, LD,  3'b100, 0);
        #2 rst = 1'b0;
        exp_q.push_back({DEC, 3'b000, 3'b000, 3'b000});
        #1;
        check("g_arst");
        #2 rst = 1'b1;
        step("g_after", 0, 0, 0, 7, 0, 0, 0, DEC, 3'b000, 0);
        step("g_hdr2",  1, 2, 0, 7, 0, 0, 0, LFD, 3'b100, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
